cdtv_ir_encoder: RTL and testbench

CDTV_IR_ENCODER -- requirements
Module: cdtv_ir_encoder

---
 rtl/cdtv_ir_encoder_if.sv | 43 ++++
 rtl/cdtv_ir_encoder.sv | 187 ++++++++++++++++++
 tb/tb_cdtv_ir_encoder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdtv_ir_encoder_if.sv
// cdtv_ir_encoder_if
// Bundles the encoder's request and status signals.
//
// Handshake: send is a level request. While idle, the encoder accepts a frame
// on any clk edge where send=1 and latches cmd on that same edge. After
// acceptance the encoder ignores cmd, and it looks at send only at the end of
// each gap. At that point, send=1 chains a repeat frame and send=0 returns the
// encoder to idle. busy stays high from acceptance to the end of the last gap.
// done pulses for exactly one clk at the end of every gap.
//
// Signals:
//   cmd       12-bit command code (master -> encoder)
//   send      frame request level (master -> encoder)
//   ir_n      IR envelope, 0 = mark, 1 = space/idle (encoder -> master)
//   busy      frame in progress (encoder -> master)
//   done      end-of-gap pulse (encoder -> master)
//   fsm_state encoder state for debug/observation (encoder -> master)
interface cdtv_ir_encoder_if;
  logic [11:0] cmd;
  logic        send;
  logic        ir_n;
  logic        busy;
  logic        done;
  logic [2:0]  fsm_state;

  modport master (
    output cmd,
    output send,
    input  ir_n,
    input  busy,
    input  done,
    input  fsm_state
  );

  modport slave (
    input  cmd,
    input  send,
    output ir_n,
    output busy,
    output done,
    output fsm_state
  );
endinterface

// File: rtl/cdtv_ir_encoder.sv
// cdtv_ir_encoder
// Generates the CDTV remote IR envelope. A data frame is made of the
// following parts, in order:
//   - a leader mark
//   - a leader space
//   - 24 pulse-distance bits, sent LSB first: cmd, then ~cmd
//   - a stop mark
//   - an idle gap
// A repeat frame sends the leader mark, a short leader space, the stop mark
// and the gap. The encoder sends repeat frames for as long as send stays high
// at the end of each gap.
// All durations count ena_1mhz strobes, and every *_US parameter must be >= 1.
//
// Ports:
//   clk       system clock
//   n_reset   synchronous active-low reset
//   ena_1mhz  one-clk 1 MHz timing strobe
//   bus       cdtv_ir_encoder_if.slave (cmd, send, ir_n, busy, done, fsm_state)
module cdtv_ir_encoder #(
  parameter int LEADER_US       = 9000,
  parameter int LEADER_SPACE_US = 4500,
  parameter int REPEAT_SPACE_US = 2100,
  parameter int BIT_MARK_US     = 400,
  parameter int ZERO_SPACE_US   = 400,
  parameter int ONE_SPACE_US    = 1200,
  parameter int GAP_US          = 40000
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              ena_1mhz,
  cdtv_ir_encoder_if.slave  bus
);

  // Size the duration counter for the longest interval.
  localparam int MAX_A   = (LEADER_US > LEADER_SPACE_US) ? LEADER_US : LEADER_SPACE_US;
  localparam int MAX_B   = (REPEAT_SPACE_US > BIT_MARK_US) ? REPEAT_SPACE_US : BIT_MARK_US;
  localparam int MAX_C   = (ZERO_SPACE_US > ONE_SPACE_US) ? ZERO_SPACE_US : ONE_SPACE_US;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_ABC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int MAX_ALL = (MAX_ABC > GAP_US) ? MAX_ABC : GAP_US;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] C_LEAD  = CNT_W'(LEADER_US);
  localparam logic [CNT_W-1:0] C_LSP   = CNT_W'(LEADER_SPACE_US);
  localparam logic [CNT_W-1:0] C_RSP   = CNT_W'(REPEAT_SPACE_US);
  localparam logic [CNT_W-1:0] C_BM    = CNT_W'(BIT_MARK_US);
  localparam logic [CNT_W-1:0] C_ZERO  = CNT_W'(ZERO_SPACE_US);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(ONE_SPACE_US);
  localparam logic [CNT_W-1:0] C_GAP   = CNT_W'(GAP_US);
  localparam logic [CNT_W-1:0] C_ONE_T = CNT_W'(1);

  localparam logic [4:0] LAST_BIT = 5'd23;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LEAD_MARK  = 3'd1,
    LEAD_SPACE = 3'd2,
    BIT_MARK   = 3'd3,
    BIT_SPACE  = 3'd4,
    STOP_MARK  = 3'd5,
    GAP        = 3'd6
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [23:0]      shreg, shreg_nxt;
  logic [4:0]       bit_cnt, bit_cnt_nxt;
  logic             rpt, rpt_nxt;
  logic             done_r, done_nxt;
  logic             last_strobe;

  // The strobe that consumes the final count of the current state. Each state
  // lasts exactly its loaded count of strobes.
  assign last_strobe = ena_1mhz && (cnt == C_ONE_T);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      rpt     <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      rpt     <= rpt_nxt;
      done_r  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    rpt_nxt     = rpt;
    done_nxt    = 1'b0;

    // Count down on strobes. A state's final strobe reloads the counter for
    // the next state instead of counting down.
    if (state != IDLE && ena_1mhz && !last_strobe) begin
      cnt_nxt = cnt - C_ONE_T;
    end

    case (state)
      IDLE: begin
        // Acceptance is not gated by ena_1mhz, so a request is taken on the
        // first clk edge that sees it.
        if (bus.send) begin
          state_nxt   = LEAD_MARK;
          cnt_nxt     = C_LEAD;
          shreg_nxt   = {~bus.cmd, bus.cmd};
          bit_cnt_nxt = '0;
          rpt_nxt     = 1'b0;
        end
      end

      LEAD_MARK: begin
        if (last_strobe) begin
          state_nxt = LEAD_SPACE;
          cnt_nxt   = rpt ? C_RSP : C_LSP;
        end
      end

      LEAD_SPACE: begin
        if (last_strobe) begin
          // A repeat frame carries no bits, so it goes straight to the stop mark.
          state_nxt = rpt ? STOP_MARK : BIT_MARK;
          cnt_nxt   = C_BM;
        end
      end

      BIT_MARK: begin
        if (last_strobe) begin
          state_nxt = BIT_SPACE;
          cnt_nxt   = shreg[0] ? C_ONE : C_ZERO;
        end
      end

      BIT_SPACE: begin
        if (last_strobe) begin
          shreg_nxt   = {1'b0, shreg[23:1]};
          bit_cnt_nxt = bit_cnt + 5'd1;
          state_nxt   = (bit_cnt == LAST_BIT) ? STOP_MARK : BIT_MARK;
          cnt_nxt     = C_BM;
        end
      end

      STOP_MARK: begin
        if (last_strobe) begin
          state_nxt = GAP;
          cnt_nxt   = C_GAP;
        end
      end

      GAP: begin
        if (last_strobe) begin
          done_nxt = 1'b1;
          if (bus.send) begin
            // send still held: chain a repeat frame so busy never drops.
            state_nxt   = LEAD_MARK;
            cnt_nxt     = C_LEAD;
            rpt_nxt     = 1'b1;
            bit_cnt_nxt = '0;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.ir_n      = !((state == LEAD_MARK) || (state == BIT_MARK) || (state == STOP_MARK));
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_cdtv_ir_encoder.sv
// tb_cdtv_ir_encoder
// Directed bench for cdtv_ir_encoder. It uses shortened timing parameters so
// that full frames, including repeat frames, run in a few thousand clocks.
// A monitor records every ir_n level run, measured in ena_1mhz strobes. Each
// frame's runs are compared against an expected queue, which is built from
// the hand-computed 24-bit word and the timing constants.
module tb_cdtv_ir_encoder;

  localparam int P_LEAD = 18;
  localparam int P_LSP  = 9;
  localparam int P_RSP  = 5;
  localparam int P_BM   = 2;
  localparam int P_ZS   = 2;
  localparam int P_OS   = 4;
  localparam int P_GAP  = 20;
  localparam int BUDGET = 5000;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEAD = 3'd1;
  localparam logic [2:0] ST_BITM = 3'd3;

  logic clk;
  logic n_reset;
  logic ena_1mhz;
  logic ena_gate;

  cdtv_ir_encoder_if bus ();

  cdtv_ir_encoder #(
    .LEADER_US       (P_LEAD),
    .LEADER_SPACE_US (P_LSP),
    .REPEAT_SPACE_US (P_RSP),
    .BIT_MARK_US     (P_BM),
    .ZERO_SPACE_US   (P_ZS),
    .ONE_SPACE_US    (P_OS),
    .GAP_US          (P_GAP)
  ) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .ena_1mhz (ena_1mhz),
    .bus      (bus)
  );

  // ---------------- clock / strobe ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int div;
    div = 0;
    ena_1mhz = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      div = (div + 1) % 4;
      ena_1mhz = (div == 0) && !ena_gate;
    end
  end

  // ---------------- monitor ----------------
  logic [16:0] act_q[$];
  int          gap_q[$];
  int          run;
  logic        last_lvl;
  int          done_cnt;
  int          done_wide;
  int          busy_falls;
  logic        done_prev;
  logic        busy_prev;

  initial begin
    run = 0; last_lvl = 1'b1; done_cnt = 0; done_wide = 0; busy_falls = 0;
    done_prev = 1'b0; busy_prev = 1'b0;
  end

  // At the negedge, ena_1mhz holds the value the next posedge samples. So run
  // counts the strobes spent at the current ir_n level.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      gap_q.push_back(run);
      done_cnt++;
      if (done_prev) done_wide++;
    end
    if (bus.ir_n !== last_lvl) begin
      act_q.push_back({last_lvl, 16'(run)});
      run = 0;
      last_lvl = bus.ir_n;
    end
    if (ena_1mhz) run++;
    if (busy_prev && (bus.busy === 1'b0)) busy_falls++;
    done_prev = (bus.done === 1'b1);
    busy_prev = (bus.busy === 1'b1);
  end

  // ---------------- scoreboard ----------------
  int checks;
  int errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < BUDGET) begin
      tick();
      n++;
    end
    check(name, 64'(done_cnt >= target), 64'd1);
  endtask

  typedef struct {
    logic [11:0] cmd;
    int          frames;
    logic [23:0] exp_word;
    bit          gate;
  } vec_t;

  task automatic run_frame(input vec_t v, input string tag);
    logic [16:0] exp_q[$];
    logic [23:0] word;
    logic [16:0] a;
    int d0, b0, w0, bad;
    logic [2:0] st0;

    act_q.delete();
    gap_q.delete();
    d0 = done_cnt; b0 = busy_falls; w0 = done_wide;

    bus.cmd  = v.cmd;
    bus.send = 1'b1;
    tick();
    check({tag, " accept_busy"}, 64'(bus.busy), 64'd1);
    if (v.frames == 1) bus.send = 1'b0;
    // A new cmd while the frame runs must not reach the frame.
    bus.cmd = ~v.cmd;

    if (v.gate) begin
      repeat (20) tick();
      st0 = bus.fsm_state;
      check({tag, " gate_in_lead"}, 64'(st0), 64'(ST_LEAD));
      ena_gate = 1'b1;
      bad = 0;
      for (int i = 0; i < 500; i++) begin
        tick();
        if (bus.ir_n !== 1'b0 || bus.fsm_state !== st0) bad++;
      end
      ena_gate = 1'b0;
      check({tag, " gate_frozen"}, 64'(bad), 64'd0);
    end

    if (v.frames > 1) begin
      wait_done(d0 + v.frames - 1, {tag, " repeat_done"});
      bus.send = 1'b0;
    end
    wait_done(d0 + v.frames, {tag, " final_done"});
    tick();
    check({tag, " busy_low"}, 64'(bus.busy), 64'd0);

    // Expected envelope: data frame, then (frames-1) repeat frames.
    exp_q.push_back({1'b0, 16'(P_LEAD)});
    exp_q.push_back({1'b1, 16'(P_LSP)});
    for (int b = 0; b < 24; b++) begin
      exp_q.push_back({1'b0, 16'(P_BM)});
      exp_q.push_back({1'b1, v.exp_word[b] ? 16'(P_OS) : 16'(P_ZS)});
    end
    exp_q.push_back({1'b0, 16'(P_BM)});
    for (int r = 1; r < v.frames; r++) begin
      exp_q.push_back({1'b1, 16'(P_GAP)});
      exp_q.push_back({1'b0, 16'(P_LEAD)});
      exp_q.push_back({1'b1, 16'(P_RSP)});
      exp_q.push_back({1'b0, 16'(P_BM)});
    end

    if (act_q.size() > 0) void'(act_q.pop_front());  // idle level before the frame
    check({tag, " seg_count"}, 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      a = (i < act_q.size()) ? act_q[i] : 17'h1ffff;
      check($sformatf("%s seg[%0d] lvl:len", tag, i), 64'(a), 64'(exp_q[i]));
    end

    word = '0;
    for (int b = 0; b < 24; b++) begin
      if (3 + 2 * b < act_q.size()) word[b] = (act_q[3 + 2 * b][15:0] == 16'(P_OS));
    end
    check({tag, " decoded_word"}, 64'(word), 64'(v.exp_word));

    check({tag, " gap_count"}, 64'(gap_q.size()), 64'(v.frames));
    for (int i = 0; i < gap_q.size(); i++) begin
      check($sformatf("%s gap[%0d]", tag, i), 64'(gap_q[i]), 64'(P_GAP));
    end
    check({tag, " done_pulses"}, 64'(done_cnt - d0), 64'(v.frames));
    check({tag, " done_width"}, 64'(done_wide - w0), 64'd0);
    check({tag, " busy_drops"}, 64'(busy_falls - b0), 64'd1);
  endtask

  // ---------------- test ----------------
  vec_t vecs[4];

  initial begin
    int n, d0;

    // Hand-computed expected words: {~cmd, cmd}.
    vecs[0] = '{cmd: 12'h000, frames: 1, exp_word: 24'hFFF000, gate: 1'b0};
    vecs[1] = '{cmd: 12'hA5C, frames: 1, exp_word: 24'h5A3A5C, gate: 1'b0};
    vecs[2] = '{cmd: 12'h3C1, frames: 3, exp_word: 24'hC3E3C1, gate: 1'b0};
    vecs[3] = '{cmd: 12'h800, frames: 2, exp_word: 24'h7FF800, gate: 1'b1};

    checks = 0; errors = 0;
    ena_gate = 1'b0;
    n_reset  = 1'b0;
    bus.send = 1'b0;
    bus.cmd  = '0;
    repeat (3) tick();
    check("reset ir_n", 64'(bus.ir_n), 64'd1);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset state", 64'(bus.fsm_state), 64'(ST_IDLE));
    n_reset = 1'b1;
    repeat (5) tick();

    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
      repeat (10) tick();
    end

    // Reset in the middle of bit 10 aborts the frame without a done pulse.
    act_q.delete();
    bus.cmd  = 12'h0F0;
    bus.send = 1'b1;
    tick();
    bus.send = 1'b0;
    n = 0;
    while (act_q.size() < 23 && n < BUDGET) begin
      tick();
      n++;
    end
    check("midreset reached bit10", 64'(act_q.size() >= 23), 64'd1);
    check("midreset in bit_mark", 64'(bus.fsm_state), 64'(ST_BITM));
    d0 = done_cnt;
    n_reset = 1'b0;
    tick();
    check("midreset ir_n", 64'(bus.ir_n), 64'd1);
    check("midreset busy", 64'(bus.busy), 64'd0);
    check("midreset state", 64'(bus.fsm_state), 64'(ST_IDLE));
    n_reset = 1'b1;
    repeat (100) tick();
    check("midreset no done", 64'(done_cnt - d0), 64'd0);
    run_frame('{cmd: 12'h5A5, frames: 1, exp_word: 24'hA5A5A5, gate: 1'b0}, "fresh");
    repeat (10) tick();

    // send held while reset is low: stay idle, start on the first clk after release.
    n_reset  = 1'b0;
    bus.send = 1'b1;
    bus.cmd  = 12'h123;
    repeat (5) tick();
    check("rst+send busy", 64'(bus.busy), 64'd0);
    check("rst+send state", 64'(bus.fsm_state), 64'(ST_IDLE));
    check("rst+send ir_n", 64'(bus.ir_n), 64'd1);
    n_reset = 1'b1;
    d0 = done_cnt;
    tick();
    check("release start busy", 64'(bus.busy), 64'd1);
    check("release start state", 64'(bus.fsm_state), 64'(ST_LEAD));
    bus.send = 1'b0;
    wait_done(d0 + 1, "release frame done");
    tick();
    check("release frame busy_low", 64'(bus.busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
